csi_raw_unpacker: RTL and testbench
===================================

CSI_RAW_UNPACKER -- requirements
Module: csi_raw_unpacker

Interface
REQ-001 Parameter NUM_LANE, default top_pkg NUM_LANE; legal values 1, 2, 4; bytes per input beat.
REQ-002 Parameter RAW_BITS, default 8; legal values 8, 10, 12; bits per output pixel.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_vld  in  1  input beat valid; no backpressure exists.
REQ-006 in_sol  in  1  start of line payload; qualified by in_vld, marks the first beat of a line.
REQ-007 in_data  in  NUM_LANE*8  payload bytes; byte k sits in bits [8k+7:8k]; byte 0 is earliest.
REQ-008 out_vld  out  1  output word valid, one-cycle strobe per word.
REQ-009 out_data  out  NUM_LANE*RAW_BITS  NUM_LANE pixels; pixel j sits in bits [RAW_BITS*(j+1)-1:RAW_BITS*j]; pixel 0 is earliest.
REQ-010 flush_err  out  1  one-cycle pulse when the block discards residual bytes or pixels at in_sol.
REQ-011 ovf_err  out  1  sticky flag set when the pixel buffer overflows; cleared only by rst.

Function
REQ-012 The block SHALL decode groups of G bytes into P pixels: RAW8 uses G=1, P=1; RAW10 uses G=5, P=4; RAW12 uses G=3, P=2.
REQ-013 RAW8: pixel = byte.
REQ-014 RAW10: pixel i = {byte i, byte4[2i+1:2i]} for i = 0..3.
REQ-015 RAW12: pixel 0 = {byte0, byte2[3:0]}; pixel 1 = {byte1, byte2[7:4]}.
REQ-016 The byte buffer SHALL hold at most G-1+NUM_LANE bytes (maximum 8); each in_vld beat appends NUM_LANE bytes in order.
REQ-017 Each cycle, the block SHALL decode all complete groups present (floor(level/G)), move their pixels into the pixel buffer, and shift the remaining bytes down.
REQ-018 The pixel buffer SHALL hold 2*NUM_LANE+4 pixels; decoded pixels keep arrival order.
REQ-019 Whenever the pixel level is at least NUM_LANE, the block SHALL pop NUM_LANE pixels onto out_data with out_vld=1, one word per cycle.
REQ-020 Latency: out_vld SHALL rise 1 cycle after the in_vld beat that completes the needed group(s) when the pixel buffer was empty; there are no bubbles beyond that.
REQ-021 Sustained throughput: under continuous in_vld, no byte or pixel SHALL be lost; output word rate = 8/RAW_BITS of the input beat rate.
REQ-022 If in_vld & in_sol arrive while the byte or pixel level is non-zero, the block SHALL discard the residue, pulse flush_err the next cycle, and process the in_sol beat as the first bytes of an empty buffer.
REQ-023 If a pixel push would exceed capacity, the excess pixels SHALL be dropped and ovf_err set; this is unreachable under legal input.
REQ-024 When out_vld=0, out_data SHALL hold its last value.
REQ-025 The input beat may be non-contiguous (gaps in in_vld); partial groups SHALL be retained across gaps indefinitely.

Reset
REQ-026 With rst=1, on the next edge: out_vld=0, out_data=0, flush_err=0, ovf_err=0, byte and pixel levels=0.
REQ-027 Reset mid-line SHALL discard all buffered data; the first in_vld after reset SHALL be treated as group-aligned.
REQ-028 in_vld asserted during rst SHALL be ignored.

Structure
REQ-029 top_pkg SHALL gain a RAW_BITS localparam derived from the RAW8/RAW10/RAW12 defines, plus function-free constants RAW_GRP_BYTES and RAW_GRP_PIX; lane_raw_data_t SHALL equal the out_data width.
REQ-030 The per-group decode SHALL sit in one combinational sub-module, raw_group_decode, parameterised by RAW_BITS; buffering and control stay in csi_raw_unpacker.

Verification
REQ-031 RAW8, NUM_LANE=2: beat 0x2211 -> next cycle out_vld=1, out_data=0x2211.
REQ-032 RAW10, NUM_LANE=2: beats 0x0201, 0x0403, then 0x??E4 with byte 4=0xE4 -> out_data {p1,p0}={0x009,0x004}, then {p3,p2}={0x013,0x00E}; the leftover byte is retained.
REQ-033 RAW12, NUM_LANE=1: bytes 0xAB, 0xCD, 0x21 on 3 beats -> out_data 0xAB1, then 0xCD2 on consecutive cycles.
REQ-034 RAW10, NUM_LANE=4: 1000 continuous random beats -> the scoreboard matches every pixel, ovf_err=0, and out_vld count=800.
REQ-035 RAW12, NUM_LANE=2: in_sol after 1 residual byte -> flush_err pulses once, and the in_sol beat decodes from a clean state.
REQ-036 rst asserted mid-group, then a fresh aligned group -> no stale pixels are emitted, and the outputs are 0 during reset.

Source files
------------

// File: rtl/top_pkg.sv
// Shared configuration for the CSI-2 RAW unpacker: pixel format, lane count
// and the byte/pixel group geometry of the selected format.
package top_pkg;

`ifdef RAW12
  localparam int RAW_BITS = 12;
`elsif RAW10
  localparam int RAW_BITS = 10;
`else
  localparam int RAW_BITS = 8;
`endif

  localparam int NUM_LANE = 2;

  // Bytes per packed group and pixels decoded from one group.
  localparam int RAW_GRP_BYTES = (RAW_BITS == 10) ? 5 : (RAW_BITS == 12) ? 3 : 1;
  localparam int RAW_GRP_PIX   = (RAW_BITS == 10) ? 4 : (RAW_BITS == 12) ? 2 : 1;

  typedef logic [7:0]                     byte_t;
  typedef logic [NUM_LANE*RAW_BITS-1:0]   lane_raw_data_t;

endpackage

// File: rtl/raw_group_decode.sv
// Combinational decode of one packed RAW group into its pixels.
// RAW8 : one byte is one pixel.
// RAW10: five bytes; the fifth carries the two LSBs of each of four pixels.
// RAW12: three bytes; the third carries the four LSBs of each of two pixels.
module raw_group_decode #(
  parameter  int RAW_BITS  = 8,
  localparam int GRP_BYTES = (RAW_BITS == 10) ? 5 : (RAW_BITS == 12) ? 3 : 1,
  localparam int GRP_PIX   = (RAW_BITS == 10) ? 4 : (RAW_BITS == 12) ? 2 : 1
) (
  input  logic [GRP_BYTES*8-1:0]       i_grp,
  output logic [GRP_PIX*RAW_BITS-1:0]  o_pix
);

  generate
    if (RAW_BITS == 10) begin : g_raw10
      for (genvar i = 0; i < 4; i++) begin : g_pix
        assign o_pix[10*i +: 10] = {i_grp[8*i +: 8], i_grp[32+2*i +: 2]};
      end
    end else if (RAW_BITS == 12) begin : g_raw12
      assign o_pix[11:0]  = {i_grp[7:0],  i_grp[19:16]};
      assign o_pix[23:12] = {i_grp[15:8], i_grp[23:20]};
    end else begin : g_raw8
      assign o_pix = i_grp;
    end
  endgenerate

endmodule

// File: rtl/csi_raw_unpacker.sv
// CSI-2 RAW payload unpacker. Incoming byte beats are appended to a small
// byte window; every complete group is decoded in the same cycle and its
// pixels join a pixel FIFO, from which one NUM_LANE-pixel word is emitted
// per cycle whenever enough pixels are available. A start-of-line beat
// discards any residue so each line starts group-aligned.
module csi_raw_unpacker #(
  parameter int NUM_LANE = top_pkg::NUM_LANE,
  parameter int RAW_BITS = top_pkg::RAW_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  input  logic                         in_sol,
  input  logic [NUM_LANE*8-1:0]        in_data,
  output logic                         out_vld,
  output logic [NUM_LANE*RAW_BITS-1:0] out_data,
  output logic                         flush_err,
  output logic                         ovf_err
);

  localparam int GRP_BYTES = (RAW_BITS == 10) ? 5 : (RAW_BITS == 12) ? 3 : 1;
  localparam int GRP_PIX   = (RAW_BITS == 10) ? 4 : (RAW_BITS == 12) ? 2 : 1;
  localparam int BCAP      = GRP_BYTES - 1 + NUM_LANE;   // byte window size
  localparam int NGRP      = BCAP / GRP_BYTES;           // max groups per cycle
  localparam int NPIX      = NGRP * GRP_PIX;             // max pixels per cycle
  localparam int PCAP      = 2 * NUM_LANE + 4;           // pixel FIFO size
  localparam int PWIN      = PCAP + NPIX + NUM_LANE;     // pixel merge window
  localparam int BLW       = $clog2(BCAP + 1);
  localparam int PLW       = $clog2(PCAP + 1);

  typedef logic [RAW_BITS-1:0] pix_t;

  // Registered state
  top_pkg::byte_t               r_byte [BCAP];
  logic [BLW-1:0]               r_blvl;
  pix_t                         r_pix  [PCAP];
  logic [PLW-1:0]               r_plvl;
  logic                         r_out_vld;
  logic [NUM_LANE*RAW_BITS-1:0] r_out_data;
  logic                         r_flush_err;
  logic                         r_ovf_err;

  // Combinational next-state
  logic                         w_restart;
  logic                         w_flush;
  int                           w_blvl, w_clvl, w_ngrp, w_nused, w_rlvl;
  top_pkg::byte_t               w_cat  [BCAP];
  top_pkg::byte_t               w_rem  [BCAP];
  logic [GRP_BYTES*8-1:0]       w_grp  [NGRP];
  logic [GRP_PIX*RAW_BITS-1:0]  w_gpix [NGRP];
  int                           w_pbase, w_npix, w_ptot, w_shift, w_plvl;
  logic                         w_pop;
  logic                         w_ovf;
  pix_t                         w_pcat  [PWIN];
  pix_t                         w_pnext [PCAP];
  logic [NUM_LANE*RAW_BITS-1:0] w_word;

  // Merge held bytes with the new beat, split off complete groups, keep the rest.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a value held and infer a latch.
  always_comb begin
    w_restart = in_vld & in_sol;
    w_flush   = w_restart & ((r_blvl != '0) | (r_plvl != '0));
    w_blvl    = w_restart ? 0 : int'(r_blvl);
    w_clvl    = w_blvl + (in_vld ? NUM_LANE : 0);
    for (int i = 0; i < BCAP; i++) begin
      w_cat[i] = '0;
      if (i < w_blvl)
        w_cat[i] = r_byte[i];
      else if (i < w_clvl)
        w_cat[i] = in_data[8*(i-w_blvl) +: 8];
    end
    w_ngrp  = w_clvl / GRP_BYTES;
    w_nused = w_ngrp * GRP_BYTES;
    w_rlvl  = w_clvl - w_nused;
    for (int i = 0; i < BCAP; i++) begin
      w_rem[i] = '0;
      if (i + w_nused < BCAP)
        w_rem[i] = w_cat[i + w_nused];
    end
    for (int g = 0; g < NGRP; g++) begin
      w_grp[g] = '0;
      for (int b = 0; b < GRP_BYTES; b++)
        w_grp[g][8*b +: 8] = w_cat[g*GRP_BYTES + b];
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_dec
    raw_group_decode #(.RAW_BITS(RAW_BITS)) u_dec (
      .i_grp (w_grp[g]),
      .o_pix (w_gpix[g])
    );
  end

  // Append decoded pixels to the FIFO, pop one output word if available.
  always_comb begin
    w_pbase = w_restart ? 0 : int'(r_plvl);
    w_npix  = w_ngrp * GRP_PIX;
    w_ptot  = w_pbase + w_npix;
    for (int j = 0; j < PWIN; j++)
      w_pcat[j] = '0;
    for (int j = 0; j < PCAP; j++)
      if (j < w_pbase)
        w_pcat[j] = r_pix[j];
    for (int g = 0; g < NGRP; g++)
      for (int p = 0; p < GRP_PIX; p++)
        if (g < w_ngrp)
          w_pcat[w_pbase + g*GRP_PIX + p] = w_gpix[g][RAW_BITS*p +: RAW_BITS];
    w_pop   = (w_ptot >= NUM_LANE);
    w_shift = w_pop ? NUM_LANE : 0;
    w_plvl  = w_ptot - w_shift;
    w_ovf   = (w_plvl > PCAP);
    if (w_ovf)
      w_plvl = PCAP;
    for (int j = 0; j < PCAP; j++)
      w_pnext[j] = w_pcat[j + w_shift];
    w_word = '0;
    for (int j = 0; j < NUM_LANE; j++)
      w_word[RAW_BITS*j +: RAW_BITS] = w_pcat[j];
  end

  // Control state and outputs; synchronous reset clears levels and flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blvl      <= '0;
      r_plvl      <= '0;
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_flush_err <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_blvl      <= BLW'(w_rlvl);
      r_plvl      <= PLW'(w_plvl);
      r_out_vld   <= w_pop;
      r_flush_err <= w_flush;
      if (w_pop)
        r_out_data <= w_word;
      if (w_ovf)
        r_ovf_err <= 1'b1;
    end
  end

  // Byte and pixel storage contents follow the computed windows.
  // NOTE: storage arrays are not reset; the level registers mark which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BCAP; i++)
      r_byte[i] <= w_rem[i];
    for (int j = 0; j < PCAP; j++)
      r_pix[j] <= w_pnext[j];
  end

  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign flush_err = r_flush_err;
  assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_csi_raw_unpacker.sv
// Self-checking bench: five unpacker configurations share one input stream
// and each is compared every cycle against a queue-based reference model.
module tb_csi_raw_unpacker;

  localparam int NCFG = 5;
  localparam int LN [NCFG] = '{2, 2, 1, 4, 2};
  localparam int RB [NCFG] = '{8, 10, 12, 10, 12};

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_sol;
  logic [31:0] in_data;

  logic [NCFG-1:0] act_vld, act_flush, act_ovf;
  logic [15:0] od0;
  logic [19:0] od1;
  logic [11:0] od2;
  logic [39:0] od3;
  logic [23:0] od4;
  logic [47:0] act_data [NCFG];

  assign act_data[0] = 48'(od0);
  assign act_data[1] = 48'(od1);
  assign act_data[2] = 48'(od2);
  assign act_data[3] = 48'(od3);
  assign act_data[4] = 48'(od4);

  csi_raw_unpacker #(.NUM_LANE(2), .RAW_BITS(8)) u_r8l2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sol(in_sol), .in_data(in_data[15:0]),
    .out_vld(act_vld[0]), .out_data(od0), .flush_err(act_flush[0]), .ovf_err(act_ovf[0]));
  csi_raw_unpacker #(.NUM_LANE(2), .RAW_BITS(10)) u_r10l2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sol(in_sol), .in_data(in_data[15:0]),
    .out_vld(act_vld[1]), .out_data(od1), .flush_err(act_flush[1]), .ovf_err(act_ovf[1]));
  csi_raw_unpacker #(.NUM_LANE(1), .RAW_BITS(12)) u_r12l1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sol(in_sol), .in_data(in_data[7:0]),
    .out_vld(act_vld[2]), .out_data(od2), .flush_err(act_flush[2]), .ovf_err(act_ovf[2]));
  csi_raw_unpacker #(.NUM_LANE(4), .RAW_BITS(10)) u_r10l4 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sol(in_sol), .in_data(in_data),
    .out_vld(act_vld[3]), .out_data(od3), .flush_err(act_flush[3]), .ovf_err(act_ovf[3]));
  csi_raw_unpacker #(.NUM_LANE(2), .RAW_BITS(12)) u_r12l2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sol(in_sol), .in_data(in_data[15:0]),
    .out_vld(act_vld[4]), .out_data(od4), .flush_err(act_flush[4]), .ovf_err(act_ovf[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          bq [NCFG][$];
  int          pq [NCFG][$];
  logic        e_vld   [NCFG];
  logic        e_flush [NCFG];
  logic        e_ovf   [NCFG];
  logic [47:0] e_data  [NCFG];

  int vectors     = 0;
  int miscompares = 0;
  int vld3_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the reference model for configuration c.
  task automatic model_step(input int c, input logic r, input logic v, input logic s,
                            input logic [31:0] d);
    int l, rb, g, p;
    int b [5];
    l  = LN[c];
    rb = RB[c];
    g  = (rb == 10) ? 5 : (rb == 12) ? 3 : 1;
    p  = (rb == 10) ? 4 : (rb == 12) ? 2 : 1;
    if (r) begin
      bq[c].delete();
      pq[c].delete();
      e_vld[c]   = 1'b0;
      e_flush[c] = 1'b0;
      e_ovf[c]   = 1'b0;
      e_data[c]  = '0;
      return;
    end
    e_flush[c] = v && s && (bq[c].size() != 0 || pq[c].size() != 0);
    if (v && s) begin
      bq[c].delete();
      pq[c].delete();
    end
    if (v)
      for (int k = 0; k < l; k++)
        bq[c].push_back(int'((d >> (8*k)) & 32'hFF));
    while (bq[c].size() >= g) begin
      for (int k = 0; k < g; k++)
        b[k] = bq[c].pop_front();
      if (rb == 8)
        pq[c].push_back(b[0]);
      else if (rb == 10)
        for (int i = 0; i < 4; i++)
          pq[c].push_back(b[i] * 4 + ((b[4] >> (2*i)) & 3));
      else begin
        pq[c].push_back(b[0] * 16 + (b[2] & 15));
        pq[c].push_back(b[1] * 16 + (b[2] >> 4));
      end
    end
    while (pq[c].size() > 2*l + 4) begin
      e_ovf[c] = 1'b1;
      void'(pq[c].pop_back());
    end
    if (pq[c].size() >= l) begin
      e_vld[c]  = 1'b1;
      e_data[c] = '0;
      for (int j = 0; j < l; j++)
        e_data[c] |= 48'(pq[c].pop_front()) << (rb*j);
    end else
      e_vld[c] = 1'b0;
  endtask

  // Drive one cycle of inputs, then compare every configuration after the edge.
  task automatic cycle(input logic r, input logic v, input logic s, input logic [31:0] d);
    rst = r; in_vld = v; in_sol = s; in_data = d;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      model_step(c, r, v, s, d);
      check($sformatf("cfg%0d", c),
            {13'b0, act_vld[c], act_flush[c], act_ovf[c], act_data[c]},
            {13'b0, e_vld[c], e_flush[c], e_ovf[c], e_data[c]});
    end
    if (act_vld[3]) vld3_cnt++;
  endtask

  initial begin
    logic v, s;
    rst = 1'b1; in_vld = 1'b0; in_sol = 1'b0; in_data = '0;

    // Reset with in_vld high: beats must be ignored, outputs zero.
    cycle(1, 1, 1, 32'hDEAD_BEEF);
    cycle(1, 1, 0, 32'h1234_5678);
    check("rst_out_data", {16'b0, act_data[3]}, 64'h0);

    // RAW8, 2 lanes: output the cycle after the beat.
    cycle(0, 1, 1, 32'h0000_2211);
    check("r8_vld",  64'(act_vld[0]), 64'h1);
    check("r8_data", {16'b0, act_data[0]}, 64'h2211);

    // RAW10, 2 lanes: three beats complete one group, two words follow.
    cycle(1, 0, 0, 32'h0);
    cycle(0, 1, 1, 32'h0000_0201);
    cycle(0, 1, 0, 32'h0000_0403);
    check("r10_wait", 64'(act_vld[1]), 64'h0);
    cycle(0, 1, 0, 32'h0000_55E4);
    check("r10_w0", {16'b0, act_data[1]}, 64'h2404);
    cycle(0, 0, 0, 32'h0);
    check("r10_w1", {16'b0, act_data[1]}, 64'h4C0E);
    cycle(0, 0, 0, 32'h0);
    check("r10_hold", {15'b0, act_vld[1], act_data[1]}, 64'h4C0E);

    // RAW12, 1 lane: three single-byte beats give two consecutive pixels.
    cycle(1, 0, 0, 32'h0);
    cycle(0, 1, 1, 32'h0000_00AB);
    cycle(0, 1, 0, 32'h0000_00CD);
    cycle(0, 1, 0, 32'h0000_0021);
    check("r12_p0", {15'b0, act_vld[2], act_data[2]}, {15'b0, 1'b1, 48'hAB1});
    cycle(0, 0, 0, 32'h0);
    check("r12_p1", {15'b0, act_vld[2], act_data[2]}, {15'b0, 1'b1, 48'hCD2});

    // RAW12, 2 lanes: start of line with one residual byte flushes it.
    cycle(1, 0, 0, 32'h0);
    cycle(0, 1, 1, 32'h0000_2211);
    cycle(0, 1, 0, 32'h0000_4433);
    cycle(0, 1, 1, 32'h0000_5566);
    check("sol_flush", 64'(act_flush[4]), 64'h1);
    cycle(0, 1, 0, 32'h0000_0077);
    check("sol_once", 64'(act_flush[4]), 64'h0);
    check("sol_clean", {15'b0, act_vld[4], act_data[4]}, {15'b0, 1'b1, 48'h557667});

    // Reset mid-group, then a fresh aligned group without start of line.
    cycle(1, 0, 0, 32'h0);
    cycle(0, 1, 1, 32'h0000_0201);
    cycle(1, 1, 0, 32'h0000_0403);
    check("midrst_vld",  64'(act_vld), 64'h0);
    check("midrst_data", {16'b0, act_data[1]}, 64'h0);
    cycle(1, 1, 0, $urandom);
    cycle(0, 1, 0, 32'h0000_0201);
    cycle(0, 1, 0, 32'h0000_0403);
    cycle(0, 1, 0, 32'h0000_00E4);
    check("midrst_fresh", {15'b0, act_vld[1], act_data[1]}, {15'b0, 1'b1, 48'h2404});

    // Sustained random stream: RAW10 x4 must yield exactly 800 words.
    cycle(1, 0, 0, 32'h0);
    vld3_cnt = 0;
    for (int i = 0; i < 1000; i++)
      cycle(0, 1, (i == 0), $urandom);
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 0, 32'h0);
    check("stream_words", 64'(vld3_cnt), 64'd800);
    check("stream_ovf",   64'(act_ovf[3]), 64'h0);

    // Random stream with gaps and occasional start-of-line restarts.
    cycle(1, 0, 0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 40) == 0);
      cycle(0, v, s, $urandom);
    end
    check("final_ovf", 64'(act_ovf), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
